// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy/status flags,
// sticky overflow/underflow, and a selectable standard or
// first-word-fall-through read port.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = 0,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  input  logic [ADDR_WIDTH:0]   aempty_thresh,
  input  logic                  flag_clr,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = FIFO_DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [ADDR_WIDTH:0] r_level;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [ADDR_WIDTH:0] w_wr_ptr_nxt;
  logic [ADDR_WIDTH:0] w_rd_ptr_nxt;
  logic [ADDR_WIDTH:0] w_level_nxt;

  // Full blocks writes and empty blocks reads, which also gives the
  // read-wins-when-full / write-wins-when-empty behaviour for free.
  assign w_wr_acc     = wr_en & ~r_full;
  assign w_rd_acc     = rd_en & ~r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
  assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
  assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Pointers, level and status flags, all derived from the next-state level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == DEPTH_LVL);
      r_empty  <= (w_level_nxt == '0);
      r_afull  <= (w_level_nxt >= afull_thresh);
      r_aempty <= (w_level_nxt <= aempty_thresh);
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (flag_clr) begin
        r_overflow <= 1'b0;
      end
      if (rd_en && r_empty) begin
        r_underflow <= 1'b1;
      end else if (flag_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always on the output; rd_en only advances the pointer.
      assign rd_data  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      assign rd_valid = ~r_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;

      // Registered read: data loads on the accepting edge, valid pulses one cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
          end
        end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

  assign full      = r_full;
  assign empty     = r_empty;
  assign afull     = r_afull;
  assign aempty    = r_aempty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-read and a FWFT instance share stimulus
// and are both checked every cycle against a queue-based reference model.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          flag_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   afull_thresh = 5'd12;
  logic [AW:0]   aempty_thresh = 5'd3;

  logic [DW-1:0] rd_data_s, rd_data_f;
  logic          rd_valid_s, rd_valid_f;
  logic          full_s, empty_s, afull_s, aempty_s, overflow_s, underflow_s;
  logic          full_f, empty_f, afull_f, aempty_f, overflow_f, underflow_f;
  logic [AW:0]   level_s, level_f;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh), .flag_clr(flag_clr),
    .full(full_s), .empty(empty_s), .afull(afull_s), .aempty(aempty_s),
    .level(level_s), .overflow(overflow_s), .underflow(underflow_s)
  );

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_f), .rd_valid(rd_valid_f),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh), .flag_clr(flag_clr),
    .full(full_f), .empty(empty_f), .afull(afull_f), .aempty(aempty_f),
    .level(level_f), .overflow(overflow_f), .underflow(underflow_f)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_ovf;
  bit            m_udf;
  bit            m_valid_s;
  logic [DW-1:0] m_rd_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    m_valid_s = 1'b0;
    m_rd_s    = '0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level_s",     32'(level_s),     32'(n));
    chk("full_s",      32'(full_s),      32'(n == DEPTH));
    chk("empty_s",     32'(empty_s),     32'(n == 0));
    chk("afull_s",     32'(afull_s),     32'(n >= int'(afull_thresh)));
    chk("aempty_s",    32'(aempty_s),    32'(n <= int'(aempty_thresh)));
    chk("overflow_s",  32'(overflow_s),  32'(m_ovf));
    chk("underflow_s", 32'(underflow_s), 32'(m_udf));
    chk("rd_valid_s",  32'(rd_valid_s),  32'(m_valid_s));
    chk("rd_data_s",   32'(rd_data_s),   32'(m_rd_s));
    chk("level_f",     32'(level_f),     32'(n));
    chk("full_f",      32'(full_f),      32'(n == DEPTH));
    chk("empty_f",     32'(empty_f),     32'(n == 0));
    chk("afull_f",     32'(afull_f),     32'(n >= int'(afull_thresh)));
    chk("aempty_f",    32'(aempty_f),    32'(n <= int'(aempty_thresh)));
    chk("overflow_f",  32'(overflow_f),  32'(m_ovf));
    chk("underflow_f", 32'(underflow_f), 32'(m_udf));
    chk("rd_valid_f",  32'(rd_valid_f),  32'(n != 0));
    if (n != 0) chk("rd_data_f", 32'(rd_data_f), 32'(q[0]));
  endtask

  // One clock of stimulus: model steps from the pre-edge state, DUTs are
  // sampled 1 time unit after the rising edge.
  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
    int n;
    bit wa, ra;
    wr_en = w; rd_en = r; wr_data = d; flag_clr = clr;
    n  = q.size();
    wa = w && (n < DEPTH);
    ra = r && (n > 0);
    if (w && n == DEPTH) m_ovf = 1'b1;
    else if (clr)        m_ovf = 1'b0;
    if (r && n == 0)     m_udf = 1'b1;
    else if (clr)        m_udf = 1'b0;
    m_valid_s = ra;
    if (ra) m_rd_s = q.pop_front();
    if (wa) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flag_clr = 1'b0;
    check_all();
  endtask

  initial begin
    int bias_w;
    int bias_r;
    model_reset();
    #1 rst = 1'b1;
    #2 check_all();
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x01..0x10; afull rises at 12, aempty falls at 4
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);

    // Both requests while full: read wins, overflow untouched
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    cycle(1'b1, 1'b0, 8'hEF, 1'b0);
    cycle(1'b1, 1'b0, 8'hF0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Drain in order, then underflow and set-beats-clear
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Both requests while empty: write wins, underflow sets
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Hold at level 8 across several pointer wraps
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
    while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Out-of-range thresholds: afull never, aempty always
    afull_thresh  = 5'd20;
    aempty_thresh = 5'd31;
    for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Randomised traffic with shifting fill/drain bias and thresholds
    for (int k = 0; k < 800; k++) begin
      if (k % 50 == 0) begin
        afull_thresh  = 5'($urandom_range(0, 31));
        aempty_thresh = 5'($urandom_range(0, 31));
      end
      bias_w = ((k / 100) % 2 == 0) ? 70 : 30;
      bias_r = 100 - bias_w;
      cycle($urandom_range(0, 99) < bias_w, $urandom_range(0, 99) < bias_r,
            8'($urandom), $urandom_range(0, 19) == 0);
    end

    // FWFT: written word appears the cycle after the write edge
    afull_thresh  = 5'd12;
    aempty_thresh = 5'd3;
    while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("fwft_a5_data",  32'(rd_data_f),  32'h0000_00A5);
    chk("fwft_a5_valid", 32'(rd_valid_f), 32'd1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Asynchronous reset at level 7 discards contents immediately
    while (q.size() < 7) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 8'h3C, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_data_s", 32'(rd_data_s), 32'h0000_003C);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the data word in bits; legal range 1..256.
REQ-002 Parameter FIFO_DEPTH, default 16: number of entries; a power of two, at least 4. ADDR_WIDTH = log2(FIFO_DEPTH).
REQ-003 Parameter FWFT, default 0: read mode; 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port wr_en, input, 1 bit: write request.
REQ-008 Port wr_data, input, DATA_WIDTH bits: write data.
REQ-009 Port rd_en, input, 1 bit: read/pop request.
REQ-010 Port rd_data, output, DATA_WIDTH bits: read data.
REQ-011 Port rd_valid, output, 1 bit: rd_data qualifier.
REQ-012 Port afull_thresh, input, ADDR_WIDTH+1 bits: almost-full threshold.
REQ-013 Port aempty_thresh, input, ADDR_WIDTH+1 bits: almost-empty threshold.
REQ-014 Port flag_clr, input, 1 bit: clears the sticky error flags.
REQ-015 Outputs full, empty, afull, aempty, 1 bit each: status flags.
REQ-016 Output level, ADDR_WIDTH+1 bits: current occupancy.
REQ-017 Outputs overflow, underflow, 1 bit each: sticky error flags.

Function
REQ-018 A write SHALL be accepted when wr_en=1 and full=0; wr_data is stored at wr_ptr, and wr_ptr increments modulo FIFO_DEPTH.
REQ-019 A read SHALL be accepted when rd_en=1 and empty=0; rd_ptr increments modulo FIFO_DEPTH.
REQ-020 wr_ptr and rd_ptr SHALL be ADDR_WIDTH+1 bits wide; the extra MSB distinguishes full from empty across wrap-around.
REQ-021 level SHALL be registered and equal wr_ptr - rd_ptr, computed modulo 2^(ADDR_WIDTH+1), after each edge.
REQ-022 Occupancy update per edge: +1 for write only; -1 for read only; unchanged for both or neither.
REQ-023 When full=1 and wr_en=rd_en=1, the read SHALL be accepted, the write rejected, and level SHALL drop to FIFO_DEPTH-1.
REQ-024 When empty=1 and wr_en=rd_en=1, the write SHALL be accepted, the read rejected, and level SHALL become 1.
REQ-025 full, empty, afull and aempty SHALL be registered from the next-state level, so they are cycle-consistent with level:
- full = (level == FIFO_DEPTH)
- empty = (level == 0)
- afull = (level >= afull_thresh)
- aempty = (level <= aempty_thresh)
REQ-026 Threshold inputs SHALL take effect on the edge after they change; values above FIFO_DEPTH are legal and saturate naturally (for example, afull never asserts).
REQ-027 FWFT=0:
- rd_data SHALL be registered and loaded from mem[rd_ptr] on the edge accepting a read.
- rd_valid SHALL pulse high for exactly the following cycle.
- rd_data SHALL hold its value otherwise.
REQ-028 FWFT=1:
- rd_data SHALL present mem[rd_ptr] combinationally, with rd_valid = ~empty.
- rd_en pops the word; the next word is visible in the cycle after the pop.
REQ-029 FWFT=1: a word written into an empty FIFO SHALL become visible, with rd_valid=1, in the cycle after the write edge.
REQ-030 overflow SHALL set on any edge where wr_en=1 and full=1; underflow SHALL set on any edge where rd_en=1 and empty=1.
REQ-031 flag_clr=1 SHALL clear overflow and underflow; if a set condition occurs in the same cycle, the set wins.
REQ-032 Rejected requests SHALL change neither pointers nor memory contents.

Reset
REQ-033 While rst=1, asynchronously:
- wr_ptr, rd_ptr and level = 0
- empty = 1, full = 0, afull = 0, overflow = 0, underflow = 0
- rd_valid = 0, registered rd_data = 0
- aempty = 1
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 Reset asserted mid-operation SHALL discard all stored words; the first accepted read after reset returns the first word written after reset.
REQ-036 The first write SHALL be accepted on the first rising clk edge after rst deasserts.

Verification
REQ-037 Depth=16, FWFT=0: write 0x01..0x10 -> full=1 and level=16 after the 16th edge; 16 reads return 0x01..0x10 in order, each with a one-cycle rd_valid pulse; empty=1 at the end.
REQ-038 Full FIFO, wr_en=rd_en=1 for one cycle -> read accepted, write rejected, level=15, full=0, overflow stays 0; then wr_en alone while full -> overflow=1 until flag_clr.
REQ-039 Wrap: 40 interleaved writes and reads at level 8 -> data order is preserved across three pointer wraps and level stays 8.
REQ-040 afull_thresh=12, aempty_thresh=3 -> afull rises on the edge where level reaches 12, and aempty falls on the edge where level reaches 4.
REQ-041 FWFT=1: write 0xA5 into an empty FIFO -> next cycle rd_data=0xA5 and rd_valid=1; pop -> empty=1 and rd_valid=0; rd_en while empty -> underflow=1.
REQ-042 Assert rst at level=7 -> level=0, empty=1 immediately; after release, write 0x3C then read -> 0x3C is returned.
